// File: rtl/midi_button_encoder.sv
// -----------------------------------------------------------------------------
// midi_button_encoder
//
// Turns one-cycle button press pulses into MIDI Note On / Note Off messages.
// Each press toggles the note of its button. Presses are queued in a pending
// bitmap. A round-robin arbiter chooses the next button to send. The message
// goes out as bytes on a valid/ready stream that feeds a UART transmitter.
//
// Optional feature (compile-time macro):
//   MIDI_RUNNING_STATUS_EN - the status byte is left out when it equals the
//                            status byte of the last message sent.
//
// Parameters:
//   NUM_BTN   - number of buttons (1..16)
//   CHANNEL   - MIDI channel, placed in the low nibble of the status byte (0..15)
//   BASE_NOTE - note number of button 0; button i sends BASE_NOTE+i
//   VELOCITY  - Note On velocity (1..127); Note Off always uses 0x40
//
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   btn_raised - one-cycle press pulses, one bit per button
//   tx_data    - MIDI byte to the UART TX (0x00 when idle)
//   tx_valid   - tx_data holds a byte
//   tx_ready   - UART TX accepts the byte
//   notes_on   - note state per button (1 = Note On sent or in flight)
//   busy       - a message is in flight or a press is pending
// -----------------------------------------------------------------------------
module midi_button_encoder #(
   parameter int NUM_BTN   = 4,
   parameter int CHANNEL   = 0,
   parameter int BASE_NOTE = 60,
   parameter int VELOCITY  = 100
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_raised,
   output logic [7:0]         tx_data,
   output logic               tx_valid,
   input  logic               tx_ready,
   output logic [NUM_BTN-1:0] notes_on,
   output logic               busy
);

   localparam int IDX_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

   localparam logic [3:0] CHAN     = 4'(CHANNEL);
   localparam logic [7:0] STAT_ON  = {4'h9, CHAN};
   localparam logic [7:0] STAT_OFF = {4'h8, CHAN};
   localparam logic [7:0] VEL_ON   = {1'b0, 7'(VELOCITY)};
   localparam logic [7:0] VEL_OFF  = 8'h40;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STATUS,
      ST_NOTE,
      ST_VEL
   } state_e;

   state_e             state_q,    state_d;
   logic [NUM_BTN-1:0] pending_q,  pending_d;
   logic [NUM_BTN-1:0] notes_on_q, notes_on_d;
   logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
   logic [7:0]         status_q,   status_d;
   logic [7:0]         note_q,     note_d;
   logic [7:0]         vel_q,      vel_d;
`ifdef MIDI_RUNNING_STATUS_EN
   // 0x00 can never be a status byte, so the reset value never matches.
   logic [7:0]         last_status_q, last_status_d;
`endif

   logic               found;
   logic [IDX_W-1:0]   sel_idx;
   logic               capture;
   logic               handshake;
   logic [NUM_BTN-1:0] cap_mask;
   logic               new_on;
   logic [7:0]         status_new;

   // -------------------------------------------------------------------------
   // Round-robin search: first pending bit at or above rr_ptr, with wrap-around.
   // -------------------------------------------------------------------------
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      // NOTE: every variable gets a value before any branch. A path that
      // leaves a combinational variable unassigned would create a latch.
      found    = 1'b0;
      sel_idx  = '0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 0; k < NUM_BTN; k++) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= NUM_BTN) begin
            cand = cand - NUM_BTN;
         end
         cand_idx = IDX_W'(cand);
         if (!found && pending_q[cand_idx]) begin
            found   = 1'b1;
            sel_idx = cand_idx;
         end
      end
   end

   assign tx_valid   = (state_q != ST_IDLE);
   assign handshake  = tx_valid && tx_ready;
   assign capture    = (state_q == ST_IDLE) && found;
   assign cap_mask   = capture ? (NUM_BTN'(1) << sel_idx) : '0;
   assign new_on     = ~notes_on_q[sel_idx];
   assign status_new = new_on ? STAT_ON : STAT_OFF;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      // A new pulse in the same cycle as a capture sets the bit again.
      // The set therefore wins over the clear.
      pending_d  = (pending_q & ~cap_mask) | btn_raised;
      notes_on_d = notes_on_q;
      rr_ptr_d   = rr_ptr_q;
      status_d   = status_q;
      note_d     = note_q;
      vel_d      = vel_q;
`ifdef MIDI_RUNNING_STATUS_EN
      last_status_d = last_status_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (capture) begin
               notes_on_d = notes_on_q ^ cap_mask;
               rr_ptr_d   = (sel_idx == IDX_W'(NUM_BTN - 1)) ? '0 : sel_idx + IDX_W'(1);
               status_d   = status_new;
               note_d     = 8'((BASE_NOTE + int'(sel_idx)) & 127);
               vel_d      = new_on ? VEL_ON : VEL_OFF;
`ifdef MIDI_RUNNING_STATUS_EN
               state_d    = (status_new == last_status_q) ? ST_NOTE : ST_STATUS;
`else
               state_d    = ST_STATUS;
`endif
            end
         end
         ST_STATUS: begin
            if (handshake) begin
               state_d = ST_NOTE;
`ifdef MIDI_RUNNING_STATUS_EN
               last_status_d = status_q;
`endif
            end
         end
         ST_NOTE: begin
            if (handshake) begin
               state_d = ST_VEL;
            end
         end
         ST_VEL: begin
            if (handshake) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignment. Every flop then samples
      // values from before the edge, whatever the order of the statements.
      if (rst) begin
         state_q    <= ST_IDLE;
         pending_q  <= '0;
         notes_on_q <= '0;
         rr_ptr_q   <= '0;
         status_q   <= 8'h00;
         note_q     <= 8'h00;
         vel_q      <= 8'h00;
`ifdef MIDI_RUNNING_STATUS_EN
         last_status_q <= 8'h00;
`endif
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         notes_on_q <= notes_on_d;
         rr_ptr_q   <= rr_ptr_d;
         status_q   <= status_d;
         note_q     <= note_d;
         vel_q      <= vel_d;
`ifdef MIDI_RUNNING_STATUS_EN
         last_status_q <= last_status_d;
`endif
      end
   end

   // -------------------------------------------------------------------------
   // Outputs. The message bytes stay in registers while backpressure holds
   // the stream, so tx_data stays stable until the byte is taken.
   // -------------------------------------------------------------------------
   always_comb begin
      tx_data = 8'h00;
      unique case (state_q)
         ST_STATUS: tx_data = status_q;
         ST_NOTE:   tx_data = note_q;
         ST_VEL:    tx_data = vel_q;
         default:   tx_data = 8'h00;
      endcase
   end

   assign notes_on = notes_on_q;
   assign busy     = (state_q != ST_IDLE) | (|pending_q);

endmodule

// File: tb/tb_midi_button_encoder.sv
// -----------------------------------------------------------------------------
// tb_midi_button_encoder
//
// Directed self-checking bench for midi_button_encoder with default parameters
// (4 buttons, channel 0, base note 60, velocity 100). Inputs change on the
// falling edge of clk. Outputs are sampled on the falling edge of clk.
// Define MIDI_RUNNING_STATUS_EN when building this bench if it is defined for
// the RTL build.
// -----------------------------------------------------------------------------
module tb_midi_button_encoder;

   localparam int NB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] btn_raised;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [NB-1:0] notes_on;
   logic          busy;

   int tests = 0;
   int fails = 0;

   midi_button_encoder #(
      .NUM_BTN  (NB),
      .CHANNEL  (0),
      .BASE_NOTE(60),
      .VELOCITY (100)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raised(btn_raised),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .notes_on  (notes_on),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Drives a one-cycle press pulse. Returns on the falling edge after the
   // pulse has been sampled.
   task automatic pulse(input logic [NB-1:0] m);
      btn_raised = m;
      @(negedge clk);
      btn_raised = '0;
   endtask

   // Waits a bounded time for the next handshake. Returns the byte and the
   // number of idle cycles before it. waits = -1 if no byte came.
   task automatic recv(output logic [7:0] d, output int waits);
      d     = 8'hxx;
      waits = -1;
      for (int i = 0; i < 40; i++) begin
         if (tx_valid && tx_ready) begin
            d     = tx_data;
            waits = i;
            @(negedge clk);
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      btn_raised = '0;
      tx_ready   = 1'b1;
      do_reset();
      tests++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00 || notes_on !== 4'b0000 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: got valid=%b data=%h notes=%b busy=%b, expected 0 00 0000 0",
                  tx_valid, tx_data, notes_on, busy);
      end
   endtask

   task automatic test_single_press();
      logic [7:0] d;
      int         w;
      logic [7:0] exp_q[$];
      int         wexp_q[$];

      pulse(4'b0001);
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL single_busy_pending: got %b expected 1", busy);
      end

      exp_q  = '{8'h90, 8'h3C, 8'h64, 8'h80, 8'h3C, 8'h40};
      wexp_q = '{1, 0, 0, 1, 0, 0};
      for (int i = 0; i < 6; i++) begin
         if (i == 3) begin
            tests++;
            if (notes_on !== 4'b0001 || busy !== 1'b0) begin
               fails++;
               $display("FAIL single_after_on: got notes=%b busy=%b expected 0001 0", notes_on, busy);
            end
            pulse(4'b0001);
         end
         recv(d, w);
         tests++;
         if (w != wexp_q[i] || d !== exp_q[i]) begin
            fails++;
            $display("FAIL single_byte%0d: got %h after %0d cycles, expected %h after %0d",
                     i, d, w, exp_q[i], wexp_q[i]);
         end
      end
      tests++;
      if (notes_on !== 4'b0000 || busy !== 1'b0) begin
         fails++;
         $display("FAIL single_after_off: got notes=%b busy=%b expected 0000 0", notes_on, busy);
      end
   endtask

   task automatic test_simultaneous();
      logic [7:0] d;
      int         w;
      logic [7:0] exp_q[$];
      int         wexp_q[$];

      do_reset();
      pulse(4'b1011);
      // Expected order 0, 1, 3. There is one idle cycle between messages.
      exp_q  = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3D, 8'h64, 8'h90, 8'h3F, 8'h64};
      wexp_q = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
      for (int i = 0; i < 9; i++) begin
         recv(d, w);
         tests++;
         if (w != wexp_q[i] || d !== exp_q[i]) begin
            fails++;
            $display("FAIL simul_byte%0d: got %h after %0d cycles, expected %h after %0d",
                     i, d, w, exp_q[i], wexp_q[i]);
         end
      end
      tests++;
      if (notes_on !== 4'b1011 || busy !== 1'b0) begin
         fails++;
         $display("FAIL simul_notes: got notes=%b busy=%b expected 1011 0", notes_on, busy);
      end

      // rr_ptr must have wrapped to 0. Button 0 must then come before button 1.
      pulse(4'b0011);
      exp_q  = '{8'h80, 8'h3C, 8'h40, 8'h80, 8'h3D, 8'h40};
      wexp_q = '{1, 0, 0, 1, 0, 0};
      for (int i = 0; i < 6; i++) begin
         recv(d, w);
         tests++;
         if (w != wexp_q[i] || d !== exp_q[i]) begin
            fails++;
            $display("FAIL rr_wrap_byte%0d: got %h after %0d cycles, expected %h after %0d",
                     i, d, w, exp_q[i], wexp_q[i]);
         end
      end
      tests++;
      if (notes_on !== 4'b1000) begin
         fails++;
         $display("FAIL rr_wrap_notes: got %b expected 1000", notes_on);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] d;
      int         w;

      // Here rr_ptr = 2. The search wraps around and finds button 0.
      pulse(4'b0001);
      recv(d, w);
      tests++;
      if (w != 1 || d !== 8'h90) begin
         fails++;
         $display("FAIL bp_status: got %h after %0d cycles, expected 90 after 1", d, w);
      end
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (tx_valid !== 1'b1 || tx_data !== 8'h3C) begin
            fails++;
            $display("FAIL bp_hold%0d: got valid=%b data=%h expected 1 3c", i, tx_valid, tx_data);
         end
         @(negedge clk);
      end
      tx_ready = 1'b1;
      recv(d, w);
      tests++;
      if (w != 0 || d !== 8'h3C) begin
         fails++;
         $display("FAIL bp_note: got %h after %0d cycles, expected 3c after 0", d, w);
      end
      recv(d, w);
      tests++;
      if (w != 0 || d !== 8'h64 || notes_on !== 4'b1001) begin
         fails++;
         $display("FAIL bp_vel: got %h after %0d cycles notes=%b, expected 64 after 0 notes=1001",
                  d, w, notes_on);
      end
   endtask

   task automatic test_press_during_transfer();
      logic [7:0] d;
      int         w;
      logic [7:0] exp_q[$];
      int         wexp_q[$];
      int         stray;

      pulse(4'b0100);
      recv(d, w);
      recv(d, w);
      tests++;
      if (d !== 8'h3E) begin
         fails++;
         $display("FAIL ptx_note_on: got %h expected 3e", d);
      end
      // The FSM is now in VEL. Hold it there and press button 2 twice.
      tx_ready   = 1'b0;
      btn_raised = 4'b0100;
      @(negedge clk);
      btn_raised = 4'b0000;
      @(negedge clk);
      btn_raised = 4'b0100;
      @(negedge clk);
      btn_raised = 4'b0000;
      tests++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h64) begin
         fails++;
         $display("FAIL ptx_vel_hold: got valid=%b data=%h expected 1 64", tx_valid, tx_data);
      end
      tx_ready = 1'b1;
      exp_q  = '{8'h64, 8'h80, 8'h3E, 8'h40};
      wexp_q = '{0, 1, 0, 0};
      for (int i = 0; i < 4; i++) begin
         recv(d, w);
         tests++;
         if (w != wexp_q[i] || d !== exp_q[i]) begin
            fails++;
            $display("FAIL ptx_byte%0d: got %h after %0d cycles, expected %h after %0d",
                     i, d, w, exp_q[i], wexp_q[i]);
         end
      end
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         if (tx_valid !== 1'b0) stray++;
         @(negedge clk);
      end
      tests++;
      if (stray != 0 || notes_on !== 4'b1001 || busy !== 1'b0) begin
         fails++;
         $display("FAIL ptx_single_extra: got %0d extra valid cycles notes=%b busy=%b, expected 0 1001 0",
                  stray, notes_on, busy);
      end
   endtask

   task automatic test_reset_mid_message();
      logic [7:0] d;
      int         w;
      int         stray;

      pulse(4'b0010);
      recv(d, w);
      tests++;
      if (w != 1 || d !== 8'h90) begin
         fails++;
         $display("FAIL rst_mid_status: got %h after %0d cycles, expected 90 after 1", d, w);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00 || notes_on !== 4'b0000 || busy !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_state: got valid=%b data=%h notes=%b busy=%b, expected 0 00 0000 0",
                  tx_valid, tx_data, notes_on, busy);
      end
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         if (tx_valid !== 1'b0) stray++;
         @(negedge clk);
      end
      tests++;
      if (stray != 0) begin
         fails++;
         $display("FAIL rst_mid_quiet: got %0d valid cycles expected 0", stray);
      end
   endtask

   task automatic test_running_status();
      logic [7:0] d;
      int         w;
      logic [7:0] exp_q[$];
      int         wexp_q[$];

      do_reset();
      pulse(4'b0001);
      for (int i = 0; i < 3; i++) recv(d, w);
      tests++;
      if (d !== 8'h64) begin
         fails++;
         $display("FAIL rs_first_vel: got %h expected 64", d);
      end
      pulse(4'b0010);
`ifdef MIDI_RUNNING_STATUS_EN
      exp_q  = '{8'h3D, 8'h64};
      wexp_q = '{1, 0};
`else
      exp_q  = '{8'h90, 8'h3D, 8'h64};
      wexp_q = '{1, 0, 0};
`endif
      for (int i = 0; i < exp_q.size(); i++) begin
         recv(d, w);
         tests++;
         if (w != wexp_q[i] || d !== exp_q[i]) begin
            fails++;
            $display("FAIL rs_second_byte%0d: got %h after %0d cycles, expected %h after %0d",
                     i, d, w, exp_q[i], wexp_q[i]);
         end
      end
      // After a reset the status byte must be sent again.
      do_reset();
      pulse(4'b0001);
      exp_q  = '{8'h90, 8'h3C, 8'h64};
      wexp_q = '{1, 0, 0};
      for (int i = 0; i < 3; i++) begin
         recv(d, w);
         tests++;
         if (w != wexp_q[i] || d !== exp_q[i]) begin
            fails++;
            $display("FAIL rs_after_reset_byte%0d: got %h after %0d cycles, expected %h after %0d",
                     i, d, w, exp_q[i], wexp_q[i]);
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      btn_raised = '0;
      tx_ready   = 1'b1;
      @(negedge clk);
      test_reset();
      test_single_press();
      test_simultaneous();
      test_backpressure();
      test_press_during_transfer();
      test_reset_mid_message();
      test_running_status();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
